// File: rtl/counter_step_ctrl_if.sv
// Bus between the step controller and its up/down counter: enable, buttons,
// counter feedback in one direction and step strobes plus status in the other.
interface counter_step_ctrl_if;
    logic       en;
    logic       btn_inc;
    logic       btn_dec;
    logic [3:0] cnt_value;
    logic       inc_pulse;
    logic       dec_pulse;
    logic [1:0] state;
    logic       at_limit;

    modport master (
        output en, btn_inc, btn_dec, cnt_value,
        input  inc_pulse, dec_pulse, state, at_limit
    );

    modport slave (
        input  en, btn_inc, btn_dec, cnt_value,
        output inc_pulse, dec_pulse, state, at_limit
    );
endinterface

// File: rtl/counter_step_ctrl.sv
// Button-to-step controller: one step on press, auto-repeat while held,
// saturating step strobes toward a 4-bit up/down counter.
//
// state  | meaning
// IDLE   | waiting for exactly one button
// STEP   | first step, one cycle
// DELAY  | held, counting down to auto-repeat
// REPEAT | auto-repeat, step whenever timer reaches 0
module counter_step_ctrl #(
    parameter int REPEAT_DELAY  = 8,
    parameter int REPEAT_PERIOD = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    counter_step_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STEP   = 2'd1,
        S_DELAY  = 2'd2,
        S_REPEAT = 2'd3
    } state_t;

    localparam logic [7:0] DLY_LOAD = 8'(REPEAT_DELAY - 1);
    localparam logic [7:0] PER_LOAD = 8'(REPEAT_PERIOD - 1);

    state_t     r_state;
    logic       r_dir;
    logic [7:0] r_timer;

    logic w_sel_btn;
    logic w_step;
    logic w_at_max;
    logic w_at_min;

    // The opposite button is never looked at once a direction is latched.
    assign w_sel_btn = r_dir ? bus.btn_inc : bus.btn_dec;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= S_IDLE;
            r_dir   <= 1'b0;
            r_timer <= 8'd0;
        end else if (!bus.en) begin
            r_state <= S_IDLE;
            r_timer <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.btn_inc ^ bus.btn_dec) begin
                        r_dir   <= bus.btn_inc;
                        r_state <= S_STEP;
                    end
                end
                S_STEP: begin
                    r_timer <= DLY_LOAD;
                    r_state <= S_DELAY;
                end
                S_DELAY: begin
                    if (!w_sel_btn) begin
                        r_state <= S_IDLE;
                        r_timer <= 8'd0;
                    end else if (r_timer == 8'd0) begin
                        r_state <= S_REPEAT;
                    end else begin
                        r_timer <= r_timer - 8'd1;
                    end
                end
                S_REPEAT: begin
                    if (!w_sel_btn) begin
                        r_state <= S_IDLE;
                        r_timer <= 8'd0;
                    end else if (r_timer == 8'd0) begin
                        r_timer <= PER_LOAD;
                    end else begin
                        r_timer <= r_timer - 8'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_timer <= 8'd0;
                end
            endcase
        end
    end

    assign w_step   = (r_state == S_STEP) || ((r_state == S_REPEAT) && (r_timer == 8'd0));
    assign w_at_max = (bus.cnt_value == 4'd15);
    assign w_at_min = (bus.cnt_value == 4'd0);

    // Strobes are gated by the live count so the counter saturates instead of wrapping.
    assign bus.inc_pulse = w_step &  r_dir & bus.en & ~w_at_max;
    assign bus.dec_pulse = w_step & ~r_dir & bus.en & ~w_at_min;
    assign bus.state     = r_state;
    assign bus.at_limit  = (r_state != S_IDLE) && (r_dir ? w_at_max : w_at_min);
endmodule

// File: tb/tb_counter_step_ctrl.sv
// Bench for counter_step_ctrl: two instances (short and default timing) share
// stimulus; each is compared every cycle with an elapsed-time reference model.
module tb_counter_step_ctrl;
    logic clk = 1'b0;
    logic rst_s;
    logic en_s;

    always #5 clk = ~clk;

    counter_step_ctrl_if bus0();
    counter_step_ctrl_if bus1();

    counter_step_ctrl #(.REPEAT_DELAY(4), .REPEAT_PERIOD(2)) u_dut0 (
        .i_clk (clk),
        .i_rst (rst_s),
        .bus   (bus0.slave)
    );

    counter_step_ctrl u_dut1 (
        .i_clk (clk),
        .i_rst (rst_s),
        .bus   (bus1.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a press is tracked by how many cycles it has been active.
    int         d_m[2] = '{4, 8};
    int         p_m[2] = '{2, 4};
    bit         act_m[2];
    bit         dir_m[2];
    int         age_m[2];
    logic [3:0] cnt_m[2];
    bit         ep_inc[2];
    bit         ep_dec[2];
    int         seen_inc[2];
    int         seen_dec[2];
    bit         btn_i, btn_d;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int exp_state(input int i);
        if (!act_m[i])               return 0;
        if (age_m[i] == 1)           return 1;
        if (age_m[i] <= d_m[i] + 1)  return 2;
        return 3;
    endfunction

    function automatic bit exp_step(input int i);
        if (!act_m[i]) return 1'b0;
        if (age_m[i] == 1) return 1'b1;
        return (age_m[i] >= d_m[i] + 2) && (((age_m[i] - d_m[i] - 2) % p_m[i]) == 0);
    endfunction

    task automatic check_all();
        logic [1:0] o_state;
        logic       o_inc, o_dec, o_lim;
        bit         e_lim;
        for (int i = 0; i < 2; i++) begin
            if (i == 0) begin
                o_state = bus0.state; o_inc = bus0.inc_pulse; o_dec = bus0.dec_pulse; o_lim = bus0.at_limit;
            end else begin
                o_state = bus1.state; o_inc = bus1.inc_pulse; o_dec = bus1.dec_pulse; o_lim = bus1.at_limit;
            end
            ep_inc[i] = exp_step(i) &&  dir_m[i] && en_s && (cnt_m[i] != 4'd15);
            ep_dec[i] = exp_step(i) && !dir_m[i] && en_s && (cnt_m[i] != 4'd0);
            e_lim     = act_m[i] && (dir_m[i] ? (cnt_m[i] == 4'd15) : (cnt_m[i] == 4'd0));
            chk($sformatf("u%0d state", i),     32'(o_state), 32'(exp_state(i)));
            chk($sformatf("u%0d inc_pulse", i), 32'(o_inc),   32'(ep_inc[i]));
            chk($sformatf("u%0d dec_pulse", i), 32'(o_dec),   32'(ep_dec[i]));
            chk($sformatf("u%0d at_limit", i),  32'(o_lim),   32'(e_lim));
            chk($sformatf("u%0d exclusive", i), 32'(o_inc & o_dec), 32'd0);
            if (o_inc === 1'b1) seen_inc[i]++;
            if (o_dec === 1'b1) seen_dec[i]++;
        end
    endtask

    task automatic model_edge(input bit r, input bit e, input bit bi, input bit bd);
        for (int i = 0; i < 2; i++) begin
            if (ep_inc[i]) cnt_m[i] = cnt_m[i] + 4'd1;
            if (ep_dec[i]) cnt_m[i] = cnt_m[i] - 4'd1;
            if (!r) begin
                act_m[i] = 1'b0;
                dir_m[i] = 1'b0;
            end else if (!e) begin
                act_m[i] = 1'b0;
            end else if (!act_m[i]) begin
                if (bi ^ bd) begin
                    act_m[i] = 1'b1;
                    age_m[i] = 1;
                    dir_m[i] = bi;
                end
            end else if (age_m[i] == 1) begin
                age_m[i] = 2;
            end else if (dir_m[i] ? bi : bd) begin
                age_m[i]++;
            end else begin
                act_m[i] = 1'b0;
            end
        end
    endtask

    task automatic cyc(input bit r, input bit e, input bit bi, input bit bd);
        rst_s = r;
        en_s  = e;
        bus0.en = e; bus0.btn_inc = bi; bus0.btn_dec = bd; bus0.cnt_value = cnt_m[0];
        bus1.en = e; bus1.btn_inc = bi; bus1.btn_dec = bd; bus1.cnt_value = cnt_m[1];
        #2;
        check_all();
        @(posedge clk);
        model_edge(r, e, bi, bd);
        #1;
    endtask

    task automatic set_cnt(input logic [3:0] v);
        cnt_m[0] = v;
        cnt_m[1] = v;
    endtask

    task automatic clear_seen();
        for (int i = 0; i < 2; i++) begin
            seen_inc[i] = 0;
            seen_dec[i] = 0;
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            act_m[i] = 1'b0; dir_m[i] = 1'b0; age_m[i] = 0;
            ep_inc[i] = 1'b0; ep_dec[i] = 1'b0;
        end
        set_cnt(4'd5);
        clear_seen();
        rst_s = 1'b0; en_s = 1'b1;
        bus0.en = 1'b1; bus0.btn_inc = 1'b0; bus0.btn_dec = 1'b0; bus0.cnt_value = 4'd5;
        bus1.en = 1'b1; bus1.btn_inc = 1'b0; bus1.btn_dec = 1'b0; bus1.cnt_value = 4'd5;
        @(posedge clk);
        #1;
        cyc(0, 1, 1, 0);
        cyc(1, 1, 0, 0);

        // single tap
        set_cnt(4'd5);
        clear_seen();
        cyc(1, 1, 1, 0);
        repeat (4) cyc(1, 1, 0, 0);
        chk("tap_pulses_u0", 32'(seen_inc[0]), 32'd1);
        chk("tap_pulses_u1", 32'(seen_inc[1]), 32'd1);

        // hold up from 3: short timing pulses at 1,6,8,10; default at 1,10
        set_cnt(4'd3);
        clear_seen();
        repeat (11) cyc(1, 1, 1, 0);
        cyc(1, 1, 0, 0);
        chk("hold_pulses_u0", 32'(seen_inc[0]), 32'd4);
        chk("hold_pulses_u1", 32'(seen_inc[1]), 32'd2);
        repeat (2) cyc(1, 1, 0, 0);

        // saturation both ways
        set_cnt(4'd15);
        clear_seen();
        repeat (14) cyc(1, 1, 1, 0);
        cyc(1, 1, 0, 0);
        set_cnt(4'd0);
        repeat (14) cyc(1, 1, 0, 1);
        cyc(1, 1, 0, 0);
        chk("sat_pulses_u0", 32'(seen_inc[0] + seen_dec[0]), 32'd0);

        // conflict in IDLE, then opposite button during up-repeat
        set_cnt(4'd2);
        clear_seen();
        repeat (4) cyc(1, 1, 1, 1);
        chk("conflict_idle", 32'(seen_inc[0] + seen_dec[0]), 32'd0);
        repeat (6) cyc(1, 1, 1, 0);
        repeat (8) cyc(1, 1, 1, 1);
        cyc(1, 1, 0, 0);
        chk("conflict_nodec", 32'(seen_dec[0] + seen_dec[1]), 32'd0);
        cyc(1, 1, 0, 0);

        // enable drop mid-repeat, reset mid-delay, restart
        set_cnt(4'd4);
        repeat (8) cyc(1, 1, 1, 0);
        cyc(1, 0, 1, 0);
        cyc(1, 1, 0, 0);
        repeat (3) cyc(1, 1, 1, 0);
        cyc(0, 1, 1, 0);
        repeat (7) cyc(1, 1, 1, 0);
        cyc(1, 1, 0, 0);

        // default-timing dec hold from 9 down to the floor
        set_cnt(4'd9);
        clear_seen();
        repeat (60) cyc(1, 1, 0, 1);
        chk("dec_to_zero_u1", 32'(seen_dec[1]), 32'd9);
        chk("dec_floor_u1", 32'(bus1.at_limit), 32'd1);
        cyc(1, 1, 0, 0);

        // randomized traffic with sticky buttons and boundary-biased counts
        btn_i = 1'b0;
        btn_d = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            bit r, e;
            if ($urandom_range(7) == 0) btn_i = ~btn_i;
            if ($urandom_range(9) == 0) btn_d = ~btn_d;
            r = ($urandom_range(60) != 0);
            e = ($urandom_range(25) != 0);
            if ($urandom_range(40) == 0) begin
                case ($urandom_range(2))
                    0:       set_cnt(4'd0);
                    1:       set_cnt(4'd15);
                    default: set_cnt(4'($urandom_range(15)));
                endcase
            end
            cyc(r, e, btn_i, btn_d);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/counter_step_ctrl.md
COUNTER_STEP_CTRL -- requirements
Module: counter_step_ctrl

Interface
REQ-001 The block SHALL have parameter REPEAT_DELAY, default 8, meaning cycles a button must stay held after the first step before auto-repeat starts (legal 1..256).
REQ-002 The block SHALL have parameter REPEAT_PERIOD, default 4, meaning cycles between auto-repeat steps (legal 1..256).
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-low: sampled only on the rising edge of clk, asserted when 0.
REQ-005 en  input  1  controller enable; also drives the counter's en.
REQ-006 btn_inc  input  1  level request to count up (already debounced).
REQ-007 btn_dec  input  1  level request to count down (already debounced).
REQ-008 cnt_value  input  4  current counter value (digit0) fed back from the up/down counter.
REQ-009 inc_pulse  output  1  one-cycle increase strobe to the counter.
REQ-010 dec_pulse  output  1  one-cycle decrease strobe to the counter.
REQ-011 state  output  2  FSM state: 0 IDLE, 1 STEP, 2 DELAY, 3 REPEAT.
REQ-012 at_limit  output  1  selected direction is blocked by saturation.

Function
REQ-013 Internal registers SHALL be: 2-bit state, 1-bit dir (1 = up), 8-bit timer.
REQ-014 IDLE: en=1 and exactly one of btn_inc/btn_dec high at an edge -> latch dir, go STEP; both high or neither -> stay IDLE, no pulse.
REQ-015 STEP: lasts exactly one cycle; on exit load timer = REPEAT_DELAY-1, go DELAY.
REQ-016 DELAY: selected button still high -> timer decrements each edge; at timer=0 go REPEAT with timer=0; selected button low -> IDLE.
REQ-017 REPEAT: selected button high -> at timer=0 reload timer = REPEAT_PERIOD-1, else decrement; selected button low -> IDLE.
REQ-018 The opposite button SHALL be ignored in STEP/DELAY/REPEAT; direction changes only via IDLE.
REQ-019 en=0 in any state SHALL force IDLE at the next edge, with timer cleared.
REQ-020 A step SHALL occur in every cycle with state=STEP, and in every cycle with state=REPEAT and timer=0.
REQ-021 inc_pulse = step & dir & en & (cnt_value != 15); dec_pulse = step & ~dir & en & (cnt_value != 0). Both are decoded from registered state with no extra latency.
REQ-022 inc_pulse and dec_pulse SHALL never be high in the same cycle.
REQ-023 Saturation: no inc_pulse at cnt_value=15 and no dec_pulse at cnt_value=0 (no wrap). The FSM keeps sequencing while blocked.
REQ-024 at_limit SHALL be 1 when state!=IDLE and (dir=1 and cnt_value=15, or dir=0 and cnt_value=0); otherwise 0.
REQ-025 Latency: button sampled at edge k -> first pulse in cycle k+1 -> second pulse REPEAT_DELAY+1 cycles later -> further pulses every REPEAT_PERIOD cycles.

Reset
REQ-026 rst=0 at a rising edge SHALL set state=IDLE, dir=0, timer=0, so that inc_pulse=dec_pulse=at_limit=0 in the following cycle, regardless of the current state (including mid-DELAY or mid-REPEAT).
REQ-027 rst=0 SHALL take priority over en and the buttons; the first request can be accepted at the first edge with rst=1.

Verification (REPEAT_DELAY=4, REPEAT_PERIOD=2 unless stated)
REQ-028 Single tap: cnt_value=5, btn_inc high for one edge -> exactly one inc_pulse cycle, state sequence 1, 2, then 0.
REQ-029 Hold up: cnt_value=3, btn_inc held -> inc_pulse in cycles 1, 6, 8, 10, ... (relative to the sampling edge); release -> IDLE at the next edge with no further pulses.
REQ-030 Saturation: cnt_value=15 with btn_inc held, and cnt_value=0 with btn_dec held -> no pulses, at_limit=1 while state!=0.
REQ-031 Conflict: btn_inc and btn_dec both high in IDLE -> state stays 0, no pulses; press btn_dec while up-repeat is running -> up pulses continue, no dec_pulse.
REQ-032 Enable and reset: en=0 mid-REPEAT -> state=0 at the next edge, no pulses; rst=0 mid-DELAY -> all outputs 0 in the next cycle; a new press after rst=1 restarts the sequence from cycle 1.
REQ-033 Defaults: REPEAT_DELAY=8, REPEAT_PERIOD=4, btn_dec held from cnt_value=9 -> dec_pulse in cycles 1, 10, 14, 18, ... until cnt_value=0, then at_limit=1.
